// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared constants and types for the port-A RAM arbiter.
//   NREQ_DEF / ADDR_W_DEF / DATA_W_DEF : default requester count and RAM geometry
//   req_idx_t                          : requester index, wide enough for up to 8 requesters
package ram_arb_pkg;

  localparam int NREQ_DEF   = 3;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  // clog2 of the largest supported requester count (8)
  localparam int REQ_IDX_W  = 3;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick
// Rotate-priority encoder: picks the first set bit of 'eligible' at or after
// 'ptr', scanning upward and wrapping from NREQ-1 back to 0. Tying 'ptr' to 0
// turns it into a plain lowest-index-wins priority encoder.
//   eligible : in  NREQ  candidate vector
//   ptr      : in  idx   index with highest priority this cycle (must be < NREQ)
//   winner   : out idx   selected index (0 when nothing is eligible)
//   found    : out 1     at least one eligible bit was set
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] eligible,
  input  req_idx_t        ptr,
  output req_idx_t        winner,
  output logic            found
);

  // Two passes over constant indices: first the indices at or above the
  // pointer, then the wrapped-around ones below it.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && eligible[i] && (req_idx_t'(i) >= ptr)) begin
        winner = req_idx_t'(i);
        found  = 1'b1;
      end else begin
        // keep the earlier pick
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && eligible[i]) begin
        winner = req_idx_t'(i);
        found  = 1'b1;
      end else begin
        // keep the earlier pick
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares port A of the dual-port ram_block between NREQ requesters with a
// registered issue stage and a tracked synchronous-read return path.
//
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer). Undefined (default) gives round-robin.
//
// Ports:
//   clk       in   1            system clock
//   reset     in   1            asynchronous active-low reset
//   req       in   NREQ         per-requester request, held until its gnt
//   we        in   NREQ         per-requester write enable
//   addr      in   NREQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata     in   NREQ*DATA_W  flattened write data, same packing
//   gnt       out  NREQ         one-hot grant pulse
//   rvalid    out  NREQ         one-hot read-data-valid pulse, two cycles after gnt
//   rdata     out  DATA_W       read data, valid with rvalid
//   ram_addr  out  ADDR_W       to ram_block a_address
//   ram_we    out  1            to ram_block a_we
//   ram_wdata out  DATA_W       to ram_block a_writeData
//   ram_rdata in   DATA_W       from ram_block a_out
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_we,
  output logic [DATA_W-1:0]      ram_wdata,
  input  logic [DATA_W-1:0]      ram_rdata
);

  logic [NREQ-1:0]   eligible_s;
  req_idx_t          ptr_s;
  req_idx_t          winner_s;
  logic              found_s;

  logic [NREQ-1:0]   gnt_d,       gnt_q;
  logic              ram_we_d,    ram_we_q;
  logic [ADDR_W-1:0] ram_addr_d,  ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_d, ram_wdata_q;
  logic [NREQ-1:0]   rd_track_d,  rd_track_q;
  logic [NREQ-1:0]   rvalid_d,    rvalid_q;
  logic [DATA_W-1:0] rdata_d,     rdata_q;

  // A requester granted last cycle still has its stale req high; mask it so
  // it is never granted twice for one request.
  assign eligible_s = req & ~gnt_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  localparam req_idx_t LAST_IDX = req_idx_t'(NREQ - 1);
  req_idx_t ptr_d, ptr_q;
  assign ptr_s = ptr_q;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .eligible (eligible_s),
    .ptr      (ptr_s),
    .winner   (winner_s),
    .found    (found_s)
  );

  // Issue stage: route the winner's command to the RAM port and advance the pointer.
  always_comb begin
    gnt_d       = '0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (found_s) begin
      for (int i = 0; i < NREQ; i++) begin
        if (winner_s == req_idx_t'(i)) begin
          gnt_d[i]    = 1'b1;
          ram_we_d    = we[i];
          ram_addr_d  = addr[i*ADDR_W +: ADDR_W];
          ram_wdata_d = wdata[i*DATA_W +: DATA_W];
        end else begin
          // not the winner
        end
      end
`ifndef RAM_ARB_FIXED_PRIO_EN
      ptr_d = (winner_s == LAST_IDX) ? req_idx_t'(0) : (winner_s + req_idx_t'(1));
`endif
    end else begin
      // idle cycle: address/data hold, write strobe already cleared
    end
  end

  // Read return: a read issued at edge E is captured by the RAM at E+1; its
  // output is registered here at E+2, together with the requester's rvalid.
  always_comb begin
    rd_track_d = gnt_q & {NREQ{~ram_we_q}};
    rvalid_d   = rd_track_q;
    if (|rd_track_q) begin
      rdata_d = ram_rdata;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers; reset discards any read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_track_q  <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      gnt_q       <= gnt_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_track_q  <= rd_track_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter with a behavioural read-before-write RAM on
// port A. Stimulus pushes expected grants and read returns into queues; a
// negedge monitor pops and compares whenever gnt or rvalid is non-zero.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [35:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [15:0] rdata;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Synchronous RAM, read-before-write
  logic [15:0] mem [4096];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct packed {
    logic [2:0]  g;
    logic        w;
    logic [11:0] a;
    logic [15:0] d;
  } gexp_t;

  typedef struct packed {
    logic [2:0]  v;
    logic [15:0] d;
  } rexp_t;

  gexp_t exp_g[$];
  rexp_t exp_r[$];
  int    lat_q[$];
  gexp_t ge;
  rexp_t re;
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  logic  mon_en = 1'b0;
  logic [15:0] pre [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic [11:0] a, input logic [15:0] d);
    addr[i*12 +: 12]  = a;
    wdata[i*16 +: 16] = d;
  endtask

  task automatic push_g(input logic [2:0] g, input logic w, input logic [11:0] a, input logic [15:0] d);
    gexp_t e;
    e.g = g; e.w = w; e.a = a; e.d = d;
    exp_g.push_back(e);
  endtask

  task automatic push_r(input logic [2:0] v, input logic [15:0] d);
    rexp_t e;
    e.v = v; e.d = d;
    exp_r.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_gnt"},       {29'd0, gnt},       32'd0);
    chk({tag, "_rvalid"},    {29'd0, rvalid},    32'd0);
    chk({tag, "_ram_we"},    {31'd0, ram_we},    32'd0);
    chk({tag, "_ram_addr"},  {20'd0, ram_addr},  32'd0);
    chk({tag, "_ram_wdata"}, {16'd0, ram_wdata}, 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or read data
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (!reset) lat_q.delete();
      if (gnt !== 3'b000) begin
        if (exp_g.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_extra: got gnt=%b expected no grant (t=%0t)", gnt, $time);
        end else begin
          ge = exp_g.pop_front();
          chk("gnt",       {29'd0, gnt},       {29'd0, ge.g});
          chk("ram_we",    {31'd0, ram_we},    {31'd0, ge.w});
          chk("ram_addr",  {20'd0, ram_addr},  {20'd0, ge.a});
          chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, ge.d});
          if (!ge.w) lat_q.push_back(cyc + 2);
        end
      end else begin
        chk("idle_we", {31'd0, ram_we}, 32'd0);
      end
      if (rvalid !== 3'b000) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL rvalid_extra: got rvalid=%b expected none (t=%0t)", rvalid, $time);
        end else begin
          re = exp_r.pop_front();
          chk("rvalid", {29'd0, rvalid}, {29'd0, re.v});
          chk("rdata",  {16'd0, rdata},  {16'd0, re.d});
          if (lat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_latency: got rvalid with no read grant outstanding (t=%0t)", $time);
          end else begin
            chk("rd_latency", cyc, lat_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    req   = 3'b000;
    we    = 3'b000;
    addr  = 36'd0;
    wdata = 48'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h400] = 16'h0011;
    mem[12'h401] = 16'h0022;
    mem[12'h402] = 16'h0033;
    pre[0] = 16'h0011; pre[1] = 16'h0022; pre[2] = 16'h0033;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("init");
    tick();
    reset  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Reset mid-read: req1 reads 0x400, reset one cycle after the grant
    req = 3'b010; we = 3'b000; set_port(1, 12'h400, 16'h0000);
    push_g(3'b010, 1'b0, 12'h400, 16'h0000);
    tick();
    req = 3'b000;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset("midread");
    tick();
    reset = 1'b1;
    repeat (3) tick();

    // All three read continuously from reset
    req = 3'b111; we = 3'b000;
    set_port(0, 12'h400, 16'h0000);
    set_port(1, 12'h401, 16'h0000);
    set_port(2, 12'h402, 16'h0000);
    for (int k = 0; k < 6; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      push_g(3'b001 << (k % 2), 1'b0, 12'h400 + 12'(k % 2), 16'h0000);
      push_r(3'b001 << (k % 2), pre[k % 2]);
`else
      push_g(3'b001 << (k % 3), 1'b0, 12'h400 + 12'(k % 3), 16'h0000);
      push_r(3'b001 << (k % 3), pre[k % 3]);
`endif
    end
    repeat (6) tick();
    req = 3'b000;
    repeat (4) tick();

    // req0 writes 0x002F to 0x401, reads it back two cycles later
    req = 3'b001; we = 3'b001; set_port(0, 12'h401, 16'h002F);
    push_g(3'b001, 1'b1, 12'h401, 16'h002F);
    tick();
    req = 3'b000; we = 3'b000;
    tick();
    req = 3'b001; set_port(0, 12'h401, 16'h0000);
    push_g(3'b001, 1'b0, 12'h401, 16'h0000);
    push_r(3'b001, 16'h002F);
    tick();
    req = 3'b000;
    repeat (4) tick();

    // req2 alone holds a write for 6 cycles: granted every other cycle
    req = 3'b100; we = 3'b100; set_port(2, 12'h403, 16'h0055);
    for (int k = 0; k < 3; k++) push_g(3'b100, 1'b1, 12'h403, 16'h0055);
    repeat (6) tick();
    req = 3'b000; we = 3'b000;
    repeat (2) tick();

    // Same-address hazard at 0x402
    req = 3'b001; we = 3'b001; set_port(0, 12'h402, 16'h0071);
    push_g(3'b001, 1'b1, 12'h402, 16'h0071);
    tick();
    req = 3'b000; we = 3'b000;
    tick();
    req = 3'b001; set_port(0, 12'h402, 16'h0000);
    push_g(3'b001, 1'b0, 12'h402, 16'h0000);
    push_r(3'b001, 16'h0071);
    tick();
    req = 3'b010; we = 3'b010; set_port(1, 12'h402, 16'h00AA);
    push_g(3'b010, 1'b1, 12'h402, 16'h00AA);
    tick();
    req = 3'b000; we = 3'b000;
    tick();
    req = 3'b001; set_port(0, 12'h402, 16'h0000);
    push_g(3'b001, 1'b0, 12'h402, 16'h0000);
    push_r(3'b001, 16'h00AA);
    tick();
    req = 3'b000;
    repeat (4) tick();

    // Two requests, loser drops req before being served
    req = 3'b011; we = 3'b010;
    set_port(0, 12'h400, 16'h0000);
    set_port(1, 12'h404, 16'h1234);
`ifdef RAM_ARB_FIXED_PRIO_EN
    push_g(3'b001, 1'b0, 12'h400, 16'h0000);
    push_r(3'b001, 16'h0011);
`else
    push_g(3'b010, 1'b1, 12'h404, 16'h1234);
`endif
    tick();
    req = 3'b000; we = 3'b000;
    repeat (5) tick();

    chk("gnt_queue_drained", exp_g.size(), 32'd0);
    chk("rd_queue_drained",  exp_r.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares port A of the 16-bit x 4096 dual-port ram_block between NREQ on-chip requesters (e.g. VGA fetch, mouse-position logger, debug/seven-seg reader).
- Round-robin arbitration with a registered issue stage and a tracked one-cycle synchronous-read return.
- Sits between the requesters and ram_block in the top level. Port B stays directly owned by its existing user.

Parameters:
- NREQ, 3, number of requesters (2..8).
- ADDR_W, 12, RAM address width.
- DATA_W, 16, RAM data width.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester access request; held until gnt seen.
- we  in  NREQ  per-requester write enable (1 = write, 0 = read), qualified by req.
- addr  in  NREQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NREQ*DATA_W  flattened write data, same packing.
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- rvalid  out  NREQ  one-hot read-data-valid pulse, 1 cycle.
- rdata  out  DATA_W  read data, valid when any rvalid bit is high.
- ram_addr  out  ADDR_W  to ram_block a_address.
- ram_we  out  1  to ram_block a_we.
- ram_wdata  out  DATA_W  to ram_block a_writeData.
- ram_rdata  in  DATA_W  from ram_block a_out.

Behaviour:
- Reset (async, reset=0):
  - gnt, rvalid, ram_we, ram_addr, ram_wdata are all 0.
  - Round-robin pointer is 0, so requester 0 has highest priority.
  - Read-tracking register is cleared; any in-flight read is discarded and its rvalid never fires.
- Pipeline:
  - Arbitration at edge E: eligible = req & ~gnt. A requester whose gnt is currently high is masked, so a stale req is never double-granted.
  - Winner w = first eligible index at or after the pointer, scanning upward with wrap NREQ-1 -> 0.
  - Registered at E: ram_addr, ram_we (= we[w]) and ram_wdata come from w; gnt = one-hot(w); pointer = (w+1) mod NREQ.
  - No eligible request at E: gnt = 0, ram_we = 0, ram_addr/ram_wdata hold, pointer holds.
  - Read latency: for a read granted at E, RAM captures at E+1, and rvalid[w] = 1 with rdata = ram_rdata during the cycle after E+1. Total 2 cycles from the grant pulse to data.
  - Write: completes at E+1; no rvalid is generated.
- Handshake:
  - Requester keeps req/we/addr/wdata stable from assertion until the cycle gnt[i] is high.
  - It may deassert req, or present a new request, from the next cycle on.
- Throughput:
  - 1 access per cycle aggregate.
  - Any single requester gets at most every other cycle, because of the gnt mask.
- Boundaries:
  - All requests high: grant order 0,1,2,0,... from reset.
  - A req dropped before grant is simply not served; there is no abort side effect.
  - Read followed immediately by a write to the same address: the read returns the old data (RAM read-before-write on port A).
  - rvalid and gnt may be high in the same cycle for different requesters.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer is not implemented and is treated as constant 0. The gnt mask still applies, so requester 0 (VGA) gets at least every other cycle.
- Undefined: round-robin as above.

Decomposition:
- Package ram_arb_pkg: default NREQ/ADDR_W/DATA_W constants, and a typedef for the requester index (clog2 of NREQ max 8 = 3 bits).
- One combinational sub-module, rr_pick: rotate-priority encoder.
  - Inputs: eligible vector, pointer.
  - Outputs: winner index and a found flag.
  - Fixed priority is selected by tying the pointer to 0.

Test Plan:
- Reset mid-read: grant a read from req1 at 0x400, assert reset=0 one cycle later -> rvalid stays 0, all outputs 0, and the next grant order starts at requester 0.
- Single write then read: req0 writes 0x002F to 0x401; two cycles later req0 reads 0x401 -> gnt[0] pulses twice, ram_we=1 only for the first, rvalid[0] 2 cycles after the second gnt, rdata=0x002F.
- All three requesters read 0x400/0x401/0x402 (preloaded 0x11/0x22/0x33) continuously -> gnt sequence 001,010,100,001,...; rvalid follows 2 cycles later; rdata matches each address.
- Only req2 holds req high for 6 cycles -> gnt[2] high every other cycle (3 grants); ram_we=0 in the gap cycles.
- Same-address hazard: req0 reads 0x402 (holds 0x0071) while req1 writes 0x00AA to 0x402 in the next grant -> req0 gets 0x0071; a later read returns 0x00AA.
- RAM_ARB_FIXED_PRIO_EN defined, req0 and req1 held high for 6 cycles -> grants alternate 0,1,0,1,0,1; req2 also high -> req2 never granted while req0 and req1 are both held.
